// File: rtl/sap_cpu_core_if.sv
// Program-load and output-port bundle for sap_cpu_core.
// The master drives the prog_* write port. The slave (the core) drives the output register and its valid pulse.
interface sap_cpu_core_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              prog_en;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;

  modport master (
    output prog_en, prog_we, prog_addr, prog_data,
    input  out_data, out_valid
  );

  modport slave (
    input  prog_en, prog_we, prog_addr, prog_data,
    output out_data, out_valid
  );
endinterface

// File: rtl/sap_cpu_core.sv
// SAP-style accumulator CPU core with a muxed internal bus and internal DFF program memory.
// The program is loaded through the prog_* port while prog_en is high.
// Execution starts at address 0 once prog_en falls.
module sap_cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  sap_cpu_core_if.slave     bus,
  output logic              halted,
  output logic              cf,
  output logic              zf,
  output logic [ADDR_W-1:0] pc
);

  if (DATA_W < 4 + ADDR_W) begin : g_width_check
    $error("sap_cpu_core: DATA_W must be >= 4+ADDR_W");
  end

  typedef enum logic [2:0] {
    ST_F0, ST_F1, ST_E0, ST_E1, ST_E2, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
    OP_STA = 4'h4, OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7,
    OP_JZ  = 4'h8, OP_OUT = 4'hE, OP_HLT = 4'hF
  } opcode_e;

  state_e            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] out_q;
  logic              out_valid_q;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];
  logic [DATA_W-1:0] mem_rd;
  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W:0]   alu;

  assign mem_rd        = mem[mar];
  assign opcode        = opcode_e'(ir[DATA_W-1 -: 4]);
  assign operand       = ir[ADDR_W-1:0];
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;

  // Adder/subtractor with carry out; SUB carry = 1 means no borrow
  always_comb begin
    alu = '0;
    if (opcode == OP_SUB)
      alu = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    else
      alu = {1'b0, a} + {1'b0, b};
  end

  // Program memory: loader writes in program mode, STA writes in E1 otherwise; never reset
  always_ff @(posedge clk) begin
    if (bus.prog_en) begin
      if (bus.prog_we)
        mem[bus.prog_addr] <= bus.prog_data;
    end else if (state == ST_E1 && opcode == OP_STA) begin
      mem[mar] <= a;
    end
  end

  // Control FSM and datapath registers; prog_en overrides every state, including HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_F0;
      pc          <= '0;
      mar         <= '0;
      ir          <= '0;
      a           <= '0;
      b           <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted      <= 1'b0;
      cf          <= 1'b0;
      zf          <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.prog_en) begin
        state  <= ST_F0;
        pc     <= '0;
        halted <= 1'b0;
      end else begin
        case (state)
          ST_F0: begin
            mar   <= pc;
            state <= ST_F1;
          end
          ST_F1: begin
            ir    <= mem_rd;
            pc    <= pc + 1'b1;
            state <= ST_E0;
          end
          ST_E0: begin
            state <= ST_F0;
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                mar   <= operand;
                state <= ST_E1;
              end
              OP_LDI: a <= {{(DATA_W-ADDR_W){1'b0}}, operand};
              OP_JMP: pc <= operand;
              OP_JC:  if (cf) pc <= operand;
              OP_JZ:  if (zf) pc <= operand;
              OP_OUT: begin
                out_q       <= a;
                out_valid_q <= 1'b1;
              end
              OP_HLT: begin
                state  <= ST_HALT;
                halted <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_E1: begin
            state <= ST_F0;
            case (opcode)
              OP_LDA: a <= mem_rd;
              OP_ADD, OP_SUB: begin
                b     <= mem_rd;
                state <= ST_E2;
              end
              default: ;
            endcase
          end
          ST_E2: begin
            a     <= alu[DATA_W-1:0];
            cf    <= alu[DATA_W];
            zf    <= (alu[DATA_W-1:0] == '0);
            state <= ST_F0;
          end
          ST_HALT: state <= ST_HALT;
          default: state <= ST_F0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed testbench for sap_cpu_core with DATA_W=8 and ADDR_W=4.
// It loads small programs and checks outputs at hand-computed cycle counts.
module tb_sap_cpu_core;

  logic       clk;
  logic       rst_n;
  logic       halted;
  logic       cf;
  logic       zf;
  logic [3:0] pc;
  int         n_cmp;
  int         n_err;

  sap_cpu_core_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .halted (halted),
    .cf     (cf),
    .zf     (zf),
    .pc     (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [7:0] data);
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick(1);
  endtask

  task automatic prog_start();
    bus.prog_en = 1'b1;
    bus.prog_we = 1'b1;
  endtask

  task automatic prog_stop();
    bus.prog_we = 1'b0;
    bus.prog_en = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
  endtask

  task automatic load_sc1();
    prog_start();
    clear_mem();
    wr(4'h0, 8'h1E); wr(4'h1, 8'h2F); wr(4'h2, 8'hE0); wr(4'h3, 8'hF0);
    wr(4'hE, 8'h05); wr(4'hF, 8'h07);
    prog_stop();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b1;
    bus.prog_en = 1'b0;
    bus.prog_we = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cf", 32'(cf), 32'h0);
    chk("rst_zf", 32'(zf), 32'h0);
    tick(2);
    rst_n = 1'b1;

    // Scenario 1: LDA E, ADD F, OUT, HLT -> 5+7
    load_sc1();
    tick(11);
    chk("s1_no_early_valid", 32'(bus.out_valid), 32'h0);
    tick(1);
    chk("s1_valid", 32'(bus.out_valid), 32'h1);
    chk("s1_out", 32'(bus.out_data), 32'h0C);
    tick(1);
    chk("s1_valid_drop", 32'(bus.out_valid), 32'h0);
    tick(1);
    chk("s1_not_yet_halted", 32'(halted), 32'h0);
    tick(1);
    chk("s1_halted", 32'(halted), 32'h1);
    chk("s1_pc", 32'(pc), 32'h4);
    tick(5);
    chk("s1_halt_pc_frozen", 32'(pc), 32'h4);
    chk("s1_halt_stays", 32'(halted), 32'h1);
    chk("s1_flags", 32'({cf, zf}), 32'h0);

    // Scenario 2: LDI 3, SUB F(05) -> FE borrow, JC 9 not taken
    prog_start();
    clear_mem();
    wr(4'h0, 8'h53); wr(4'h1, 8'h3F); wr(4'h2, 8'h79); wr(4'h3, 8'hE0);
    wr(4'h4, 8'hF0); wr(4'h9, 8'hF0); wr(4'hF, 8'h05);
    chk("s2_prog_clears_halt", 32'(halted), 32'h0);
    prog_stop();
    tick(8);
    chk("s2_cf", 32'(cf), 32'h0);
    chk("s2_zf", 32'(zf), 32'h0);
    tick(3);
    chk("s2_jc_not_taken_pc", 32'(pc), 32'h3);
    tick(3);
    chk("s2_valid", 32'(bus.out_valid), 32'h1);
    chk("s2_out", 32'(bus.out_data), 32'hFE);
    tick(3);
    chk("s2_halted", 32'(halted), 32'h1);
    chk("s2_pc", 32'(pc), 32'h5);

    // Scenario 2b: LDI 5, SUB F(05) -> 0 no borrow, JC 6 taken to HLT
    prog_start();
    clear_mem();
    wr(4'h0, 8'h55); wr(4'h1, 8'h3F); wr(4'h2, 8'h76); wr(4'h3, 8'hE0);
    wr(4'h6, 8'hF0); wr(4'hF, 8'h05);
    prog_stop();
    tick(8);
    chk("s2b_cf", 32'(cf), 32'h1);
    chk("s2b_zf", 32'(zf), 32'h1);
    tick(3);
    chk("s2b_jc_taken_pc", 32'(pc), 32'h6);
    tick(3);
    chk("s2b_halted", 32'(halted), 32'h1);
    chk("s2b_pc", 32'(pc), 32'h7);
    chk("s2b_out_retained", 32'(bus.out_data), 32'hFE);

    // Scenario 3: LDI 0, ADD F(00) -> zf, JZ 8 taken, OUT 0
    prog_start();
    clear_mem();
    wr(4'h0, 8'h50); wr(4'h1, 8'h2F); wr(4'h2, 8'h88); wr(4'h3, 8'hF0);
    wr(4'h8, 8'hE0); wr(4'h9, 8'hF0);
    prog_stop();
    tick(8);
    chk("s3_zf", 32'(zf), 32'h1);
    chk("s3_cf", 32'(cf), 32'h0);
    tick(3);
    chk("s3_jz_taken_pc", 32'(pc), 32'h8);
    tick(3);
    chk("s3_valid", 32'(bus.out_valid), 32'h1);
    chk("s3_out", 32'(bus.out_data), 32'h00);
    tick(3);
    chk("s3_halted", 32'(halted), 32'h1);
    chk("s3_pc", 32'(pc), 32'hA);

    // Scenario 4: LDI A, STA D, LDI 0, LDA D, OUT; flags preserved
    prog_start();
    clear_mem();
    wr(4'h0, 8'h5A); wr(4'h1, 8'h4D); wr(4'h2, 8'h50); wr(4'h3, 8'h1D);
    wr(4'h4, 8'hE0); wr(4'h5, 8'hF0);
    prog_stop();
    tick(16);
    chk("s4_no_early_valid", 32'(bus.out_valid), 32'h0);
    tick(1);
    chk("s4_valid", 32'(bus.out_valid), 32'h1);
    chk("s4_out", 32'(bus.out_data), 32'h0A);
    chk("s4_flags_kept", 32'({cf, zf}), 32'h1);

    // prog_en while STA sits in E1 must cancel the store
    prog_start();
    clear_mem();
    wr(4'h0, 8'h57); wr(4'h1, 8'h4E); wr(4'hE, 8'h33);
    prog_stop();
    tick(6);
    prog_start();
    wr(4'h0, 8'h1E);
    chk("abort_pc", 32'(pc), 32'h0);
    wr(4'h1, 8'hE0); wr(4'h2, 8'hF0);
    prog_stop();
    tick(7);
    chk("abort_valid", 32'(bus.out_valid), 32'h1);
    chk("abort_no_store", 32'(bus.out_data), 32'h33);

    // Scenario 5: all NOP memory, PC wraps F->0; then HLT at 0
    prog_start();
    clear_mem();
    prog_stop();
    tick(45);
    chk("s5_pc_f", 32'(pc), 32'hF);
    chk("s5_not_halted", 32'(halted), 32'h0);
    tick(3);
    chk("s5_pc_wrap", 32'(pc), 32'h0);
    prog_start();
    wr(4'h0, 8'hF0);
    prog_stop();
    tick(3);
    chk("s5_halted", 32'(halted), 32'h1);
    chk("s5_pc", 32'(pc), 32'h1);

    // Scenario 6: async reset during ADD E1, then rerun from preserved memory
    load_sc1();
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_pc", 32'(pc), 32'h0);
    chk("s6_rst_out", 32'(bus.out_data), 32'h0);
    chk("s6_rst_halted", 32'(halted), 32'h0);
    chk("s6_rst_flags", 32'({cf, zf}), 32'h0);
    #2 rst_n = 1'b1;
    tick(12);
    chk("s6_valid", 32'(bus.out_valid), 32'h1);
    chk("s6_out", 32'(bus.out_data), 32'h0C);
    tick(3);
    chk("s6_halted", 32'(halted), 32'h1);
    chk("s6_pc", 32'(pc), 32'h4);
    bus.prog_en = 1'b1;
    tick(1);
    chk("s6_prog_clear_halt", 32'(halted), 32'h0);
    chk("s6_prog_pc", 32'(pc), 32'h0);
    chk("s6_out_retained", 32'(bus.out_data), 32'h0C);
    bus.prog_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
